// File: rtl/gray_position_tracker.sv
// Gray position tracker: synchronise, debounce and decode a Gray code, then classify steps and keep a position count.
// Latency: outputs update STABLE_CYCLES+2 edges after gray_in changes. No backpressure: the block always accepts its input.
module gray_position_tracker #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 3,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             clr,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             step_up,
  output logic             step_dn,
  output logic             err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] pos_count
);

  localparam int SC_W = $clog2(STABLE_CYCLES + 1);
  typedef logic [SC_W-1:0] sc_t;
  localparam sc_t SC_MAX = sc_t'(STABLE_CYCLES);

  typedef enum logic {ST_INIT, ST_TRACK} state_t;

  state_t           state;
  logic [WIDTH-1:0] sync1, sync2, cand;
  logic [1:0]       sync_vld;
  logic             cand_vld;
  sc_t              cnt, cnt_nxt;
  logic             chg, accept;
  logic [WIDTH-1:0] new_bin, delta;

  // sync_vld marks when sync2 holds a real sample, so the first code after reset
  // is counted from the edge it leaves the synchroniser, like any later change.
  always_comb begin
    chg = !cand_vld || (sync2 != cand);
    if (chg)
      cnt_nxt = sc_t'(1);
    else if (cnt == SC_MAX)
      cnt_nxt = SC_MAX;
    else
      cnt_nxt = cnt + sc_t'(1);
    accept = sync_vld[1] && (cnt_nxt == SC_MAX) && (chg || (cnt != SC_MAX));

    new_bin = '0;
    new_bin[WIDTH-1] = sync2[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--)
      new_bin[i] = new_bin[i+1] ^ sync2[i];
    delta = new_bin - bin_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      sync_vld <= '0;
      cand     <= '0;
      cand_vld <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= gray_in;
      sync2    <= sync1;
      sync_vld <= {sync_vld[0], 1'b1};
      if (sync_vld[1] && chg) begin
        cand     <= sync2;
        cand_vld <= 1'b1;
      end
      // clr restarts the stability run so re-entry into INIT needs a fresh stable period
      if (clr)
        cnt <= '0;
      else if (sync_vld[1])
        cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      bin_out    <= '0;
      bin_valid  <= 1'b0;
      step_up    <= 1'b0;
      step_dn    <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      pos_count  <= '0;
    end else begin
      step_up <= 1'b0;
      step_dn <= 1'b0;
      err     <= 1'b0;
      if (clr) begin
        state      <= ST_INIT;
        bin_valid  <= 1'b0;
        err_sticky <= 1'b0;
        pos_count  <= '0;
      end else if (accept) begin
        bin_out <= new_bin;
        case (state)
          ST_INIT: begin
            bin_valid <= 1'b1;
            state     <= ST_TRACK;
          end
          ST_TRACK: begin
            if (delta == WIDTH'(1)) begin
              step_up   <= 1'b1;
              pos_count <= pos_count + CNT_W'(1);
            end else if (delta == {WIDTH{1'b1}}) begin
              step_dn   <= 1'b1;
              pos_count <= pos_count - CNT_W'(1);
            end else if (delta != '0) begin
              err        <= 1'b1;
              err_sticky <= 1'b1;
            end
          end
          default: state <= ST_INIT;
        endcase
      end
    end
  end

endmodule
